de10nano_input_conditioner: RTL and testbench

- Input-side stage that sits directly upstream of the board PIO.
- Synchronizes, polarity-corrects and debounces the raw DE10-Nano switches and keys, then drives clean levels into the PIO's SW/KEY inputs.
- Also detects rising and falling edges and holds them as sticky event flags, readable and clearable by the CPU through a small memory-mapped register window on the same bus style as the PIO.
- Raises an optional interrupt line when an enabled event is pending.

---
 rtl/de10nano_input_conditioner_if.sv | 13 +
 rtl/de10nano_input_conditioner.sv | 132 +++++++++++++
 tb/tb_de10nano_input_conditioner.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/de10nano_input_conditioner_if.sv
// Register-window bus shared with the board PIO: write strobe, byte address, write data
// and registered read data.
interface de10nano_input_conditioner_if #(
    parameter int unsigned WIDTH = 32
);
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;

    modport master (output we, output addr, output wd, input rd);
    modport slave  (input we, input addr, input wd, output rd);
endinterface

// File: rtl/de10nano_input_conditioner.sv
// Synchronise, polarity-correct and debounce the DE10-Nano SW/KEY pins, flag edges as sticky
// events and expose them via a small register window. Define INPUT_COND_IRQ_EN for IRQ_EN/irq.
module de10nano_input_conditioner #(
    parameter int unsigned     WIDTH           = 32,
    parameter int unsigned     N_CH            = 6,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = 6'b110000,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     DEBOUNCE_CYCLES = 500000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               raw_in,
    output logic [N_CH-1:0]               clean,
    output logic [N_CH-1:0]               rise_pulse,
    output logic [N_CH-1:0]               fall_pulse,
    de10nano_input_conditioner_if.slave   bus,
    output logic                          irq
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s;
    logic [N_CH-1:0][CntW-1:0]        cnt_q, cnt_d;
    logic [N_CH-1:0]                  clean_q, clean_d;
    logic [N_CH-1:0]                  rise_q, rise_d, fall_q, fall_d;
    logic [N_CH-1:0]                  rise_pend_q, rise_pend_d, fall_pend_q, fall_pend_d;
    logic [N_CH-1:0]                  rise_clr, fall_clr, irq_en;
    logic [WIDTH-1:0]                 rd_q, rd_d;
    logic                             unused_bits;

    // Flops idle at the inactive pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW_MASK}};
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK;

    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] != clean_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    clean_d[i] = s[i];
                    rise_d[i]  = s[i];
                    fall_d[i]  = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise_clr = (bus.we && bus.addr[3:2] == 2'b01) ? bus.wd[N_CH-1:0] : '0;
    assign fall_clr = (bus.we && bus.addr[3:2] == 2'b10) ? bus.wd[N_CH-1:0] : '0;

    // A new event in the same cycle as its W1C wins.
    assign rise_pend_d = (rise_pend_q & ~rise_clr) | rise_q;
    assign fall_pend_d = (fall_pend_q & ~fall_clr) | fall_q;

    always_comb begin
        rd_d = '0;
        case (bus.addr[3:2])
            2'b00:   rd_d[N_CH-1:0] = clean_q;
            2'b01:   rd_d[N_CH-1:0] = rise_pend_q;
            2'b10:   rd_d[N_CH-1:0] = fall_pend_q;
            default: rd_d[N_CH-1:0] = irq_en;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            clean_q     <= '0;
            rise_q      <= '0;
            fall_q      <= '0;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            rd_q        <= '0;
        end else begin
            cnt_q       <= cnt_d;
            clean_q     <= clean_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            rd_q        <= rd_d;
        end
    end

`ifdef INPUT_COND_IRQ_EN
    logic [N_CH-1:0] irq_en_q;
    logic            irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (bus.we && bus.addr[3:2] == 2'b11) irq_en_q <= bus.wd[N_CH-1:0];
            irq_q <= |((rise_pend_q | fall_pend_q) & irq_en_q);
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = '0;
    assign irq    = 1'b0;
`endif

    assign clean       = clean_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign bus.rd      = rd_q;
    assign unused_bits = ^{bus.wd[WIDTH-1:N_CH], bus.addr[WIDTH-1:4], bus.addr[1:0]};

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt_chk
        a_cnt_no_wrap: assert property (@(posedge clk) disable iff (rst)
            cnt_q[i] < CntW'(DEBOUNCE_CYCLES));
    end

    a_pulse_excl: assert property (@(posedge clk) disable iff (rst) !(|(rise_q & fall_q)));
endmodule

// File: tb/tb_de10nano_input_conditioner.sv
// Scoreboarded bench for de10nano_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_de10nano_input_conditioner;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned N_CH  = 6;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] clean, rise_pulse, fall_pulse;
    logic            irq;
    int              n_checks = 0;
    int              n_fail   = 0;
    rd_exp_t         sb[$];

    de10nano_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

    de10nano_input_conditioner #(
        .WIDTH          (WIDTH),
        .N_CH           (N_CH),
        .ACTIVE_LOW_MASK(6'b110000),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .clean     (clean),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .bus       (bus),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives the address, queues the expectation, then compares once rd is produced.
    task automatic bus_read(input logic [1:0] off, input string tag, input logic [31:0] exp);
        rd_exp_t item;
        bus.we   = 1'b0;
        bus.addr = {28'd0, off, 2'b00};
        sb.push_back('{tag: tag, exp: exp});
        @(negedge clk);
        item = sb.pop_front();
        check_eq(item.tag, bus.rd, item.exp);
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] data);
        bus.we   = 1'b1;
        bus.addr = {28'd0, off, 2'b00};
        bus.wd   = data;
        @(negedge clk);
        bus.we   = 1'b0;
        bus.wd   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_CH-1:0] seen;
        logic            irq_seen;

        rst      = 1'b1;
        raw_in   = 6'b110000;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.wd   = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_clean", 32'(clean), 32'h0);
        check_eq("reset_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        check_eq("reset_irq", 32'(irq), 32'h0);
        check_eq("reset_rd", bus.rd, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_clean", 32'(clean), 32'h0);

        // Clean rise lands on the 6th edge after the pin changes.
        raw_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("ch0_not_yet", 32'(clean), 32'h0);
        @(negedge clk);
        check_eq("ch0_clean", 32'(clean), 32'h01);
        check_eq("ch0_rise", 32'(rise_pulse), 32'h01);
        @(negedge clk);
        check_eq("ch0_rise_one_cycle", 32'(rise_pulse), 32'h0);
        bus_read(2'b01, "ch0_rise_pend", 32'h1);
        bus_read(2'b00, "ch0_clean_reg", 32'h1);
        bus_write(2'b01, 32'hffff_ffff);
        bus_read(2'b01, "rise_pend_cleared", 32'h0);

        // A 3-cycle glitch is shorter than the debounce window.
        raw_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        raw_in[1] = 1'b0;
        seen = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen |= {5'd0, clean[1]} | rise_pulse | fall_pulse;
        end
        check_eq("glitch_no_activity", 32'(seen), 32'h0);
        bus_read(2'b01, "glitch_rise_pend", 32'h0);

        // KEY0 press (active-low) then release.
        raw_in[4] = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("key0_pressed", 32'(clean), 32'h11);
        raw_in[4] = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("key0_still_held", 32'(clean), 32'h11);
        @(negedge clk);
        check_eq("key0_released", 32'(clean), 32'h01);
        check_eq("key0_fall", 32'(fall_pulse), 32'h10);
        repeat (2) @(negedge clk);
        bus_read(2'b01, "key0_rise_pend", 32'h10);
        bus_read(2'b10, "key0_fall_pend", 32'h10);

        // W1C coinciding with a new rise: the set wins.
        raw_in[4] = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("key0_rise_again", 32'(rise_pulse), 32'h10);
        bus_write(2'b01, 32'h10);
        bus_read(2'b01, "set_wins", 32'h10);
        bus_write(2'b01, 32'h10);
        bus_read(2'b01, "w1c_clears", 32'h0);
        raw_in[4] = 1'b1;
        repeat (10) @(negedge clk);
        bus_write(2'b10, 32'h3f);
        bus_read(2'b10, "fall_pend_cleared", 32'h0);

`ifdef INPUT_COND_IRQ_EN
        bus_write(2'b11, 32'h1);
        bus_read(2'b11, "irq_en_rw", 32'h1);
        raw_in[0] = 1'b0;
        repeat (8) @(negedge clk);
        bus_write(2'b01, 32'h3f);
        bus_write(2'b10, 32'h3f);
        repeat (2) @(negedge clk);
        check_eq("irq_idle", 32'(irq), 32'h0);
        raw_in[0] = 1'b1;
        repeat (7) @(negedge clk);
        check_eq("irq_before", 32'(irq), 32'h0);
        @(negedge clk);
        check_eq("irq_set", 32'(irq), 32'h1);
        bus_write(2'b01, 32'h1);
        check_eq("irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check_eq("irq_cleared", 32'(irq), 32'h0);
`else
        bus_write(2'b11, 32'h3f);
        bus_read(2'b11, "irq_en_absent", 32'h0);
        irq_seen = 1'b0;
        raw_in[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            irq_seen |= irq;
        end
        raw_in[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            irq_seen |= irq;
        end
        check_eq("irq_tied_low", 32'(irq_seen), 32'h0);
        bus_read(2'b01, "rise_pend_no_irq", 32'h1);
`endif

        // Reset in the middle of a ch2 debounce.
        raw_in[2] = 1'b1;
        repeat (4) @(negedge clk);
        rst  = 1'b1;
        seen = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            seen |= rise_pulse | fall_pulse | clean;
        end
        check_eq("reset_abort", 32'(seen), 32'h0);
        check_eq("reset_irq_low", 32'(irq), 32'h0);
        rst = 1'b0;
        bus_read(2'b00, "post_rst_clean", 32'h0);
        bus_read(2'b01, "post_rst_rise_pend", 32'h0);
        bus_read(2'b10, "post_rst_fall_pend", 32'h0);
        bus_read(2'b11, "post_rst_irq_en", 32'h0);
        @(negedge clk);
        check_eq("post_rst_not_yet", 32'(clean), 32'h0);
        @(negedge clk);
        check_eq("post_rst_clean_rise", 32'(clean), 32'h05);
        check_eq("post_rst_rise_pulse", 32'(rise_pulse), 32'h05);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
